// File: rtl/ascon_ctrl_pkg.sv
// Shared definitions for the Ascon serial sequencer: FSM state codes,
// bit positions inside the fresh-randomness word, and a small helper.
package ascon_ctrl_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_START  = 3'd2;
   localparam logic [2:0] ST_WAIT   = 3'd3;
   localparam logic [2:0] ST_GAP    = 3'd4;
   localparam logic [2:0] ST_UNLOAD = 3'd5;
   localparam logic [2:0] ST_DONE   = 3'd6;

   localparam int NONCE_W = 128;
   localparam int TAG_W   = 128;
   localparam int RND_W   = 17;

   // rnd = {r128, rpt, r64[6:0], key shares, ad shares, ct shares, nonce shares}
   localparam int RND_R128      = 16;
   localparam int RND_RPT       = 15;
   localparam int RND_R64_LSB   = 8;
   localparam int RND_KEY_LSB   = 6;
   localparam int RND_AD_LSB    = 4;
   localparam int RND_CT_LSB    = 2;
   localparam int RND_NONCE_LSB = 0;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ascon_ser_shift.sv
// MSB-first parallel-in/serial-out register; zeros are shifted in behind the
// data so the serial output reads 0 once all W bits have gone out.
module ascon_ser_shift #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         msb
);

   logic [W-1:0] sreg;

   always_ff @(posedge clk) begin
      if (rst)        sreg <= '0;
      else if (load)  sreg <= din;
      else if (shift) sreg <= {sreg[W-2:0], 1'b0};
   end

   assign msb = sreg[W-1];

endmodule

// File: rtl/ascon_serial_ctrl.sv
// Sequencer between a parallel host job interface and the bit-serial 3-share
// Ascon decryption core: load, start, wait, gap, unload, present result.
module ascon_serial_ctrl
   import ascon_ctrl_pkg::*;
#(
   parameter int K         = 128,
   parameter int L         = 40,
   parameter int Y         = 80,
   parameter int START_CYC = 5,
   parameter int GAP_CYC   = 4,
   parameter int TMO       = 4096
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               job_valid,
   output logic               job_ready,
   input  logic [K-1:0]       key,
   input  logic [NONCE_W-1:0] nonce,
   input  logic [L-1:0]       ad,
   input  logic [Y-1:0]       ct,
   input  logic [RND_W-1:0]   rnd,
   output logic [2:0]         core_key,
   output logic [2:0]         core_nonce,
   output logic [2:0]         core_ad,
   output logic [2:0]         core_ct,
   output logic [6:0]         core_r64,
   output logic               core_r128,
   output logic               core_rpt,
   output logic               core_start,
   input  logic               core_ready,
   input  logic               core_pt,
   input  logic               core_tag,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [Y-1:0]       pt,
   output logic [TAG_W-1:0]   tag,
   output logic               timeout
);

   localparam int MAX = max3(max3(K, L, Y), NONCE_W, TAG_W);
   localparam int CW  = $clog2(max3(MAX, TMO, max3(START_CYC, GAP_CYC, 1)) + 1);
   localparam int PI  = $clog2(Y);
   localparam int TI  = $clog2(TAG_W);

   localparam logic [CW-1:0] LAST_SHIFT = CW'(MAX - 1);
   localparam logic [CW-1:0] LAST_START = CW'(START_CYC - 1);
   localparam logic [CW-1:0] LAST_GAP   = CW'(GAP_CYC - 1);
   localparam logic [CW-1:0] LAST_WAIT  = CW'(TMO - 1);
   localparam logic [CW-1:0] PT_BITS    = CW'(Y);
   localparam logic [CW-1:0] TAG_BITS   = CW'(TAG_W);

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic          accept;
   logic          inLoad;
   logic          keyBit, nonceBit, adBit, ctBit;

   // Handshakes are valid/ready: a transfer happens on the clock edge where
   // both are high; valid may wait on ready, and ready never waits on valid.
   assign job_ready  = (state == ST_IDLE);
   assign res_valid  = (state == ST_DONE);
   assign core_start = (state == ST_START);
   assign accept     = job_valid && job_ready;
   assign inLoad     = (state == ST_LOAD);

   ascon_ser_shift #(.W(K)) keyShift (
      .clk(clk), .rst(rst), .load(accept), .shift(inLoad), .din(key), .msb(keyBit));
   ascon_ser_shift #(.W(NONCE_W)) nonceShift (
      .clk(clk), .rst(rst), .load(accept), .shift(inLoad), .din(nonce), .msb(nonceBit));
   ascon_ser_shift #(.W(L)) adShift (
      .clk(clk), .rst(rst), .load(accept), .shift(inLoad), .din(ad), .msb(adBit));
   ascon_ser_shift #(.W(Y)) ctShift (
      .clk(clk), .rst(rst), .load(accept), .shift(inLoad), .din(ct), .msb(ctBit));

   // Data bits come straight from the shift registers; the randomness shares
   // pass through so the core gets fresh bits in the same cycle as the data.
   always_comb begin
      core_key   = '0;
      core_nonce = '0;
      core_ad    = '0;
      core_ct    = '0;
      core_r64   = '0;
      core_r128  = 1'b0;
      core_rpt   = 1'b0;
      if (inLoad) begin
         core_key   = {rnd[RND_KEY_LSB+1],   rnd[RND_KEY_LSB],   keyBit};
         core_nonce = {rnd[RND_NONCE_LSB+1], rnd[RND_NONCE_LSB], nonceBit};
         core_ad    = {rnd[RND_AD_LSB+1],    rnd[RND_AD_LSB],    adBit};
         core_ct    = {rnd[RND_CT_LSB+1],    rnd[RND_CT_LSB],    ctBit};
         core_r64   = rnd[RND_R64_LSB+6:RND_R64_LSB];
         core_r128  = rnd[RND_R128];
         core_rpt   = rnd[RND_RPT];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         pt      <= '0;
         tag     <= '0;
         timeout <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (job_valid) begin
               state   <= ST_LOAD;
               cnt     <= '0;
               timeout <= 1'b0;
               pt      <= '0;
               tag     <= '0;
            end
            ST_LOAD: if (cnt == LAST_SHIFT) begin
               state <= ST_START;
               cnt   <= '0;
            end else cnt <= cnt + CW'(1);
            ST_START: if (cnt == LAST_START) begin
               state <= ST_WAIT;
               cnt   <= '0;
            end else cnt <= cnt + CW'(1);
            // Ready wins over timeout when both land in the same cycle.
            ST_WAIT: if (core_ready) begin
               state <= ST_GAP;
               cnt   <= '0;
            end else if (cnt == LAST_WAIT) begin
               state   <= ST_DONE;
               timeout <= 1'b1;
               cnt     <= '0;
            end else cnt <= cnt + CW'(1);
            ST_GAP: if (cnt == LAST_GAP) begin
               state <= ST_UNLOAD;
               cnt   <= '0;
            end else cnt <= cnt + CW'(1);
            ST_UNLOAD: begin
               if (cnt < PT_BITS)  pt[cnt[PI-1:0]]  <= core_pt;
               if (cnt < TAG_BITS) tag[cnt[TI-1:0]] <= core_tag;
               if (cnt == LAST_SHIFT) begin
                  state <= ST_DONE;
                  cnt   <= '0;
               end else cnt <= cnt + CW'(1);
            end
            ST_DONE: if (res_ready) state <= ST_IDLE;
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
